// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC register-port scheduler:
// burst state encoding, default register map and control-byte layout.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [7:0] DEF_ADDR_SEC = 8'h21;
    localparam logic [7:0] DEF_ADDR_MIN = 8'h22;
    localparam logic [7:0] DEF_ADDR_HR  = 8'h23;
    localparam logic [7:0] DEF_ADDR_CTL = 8'h24;

    localparam int BURST_LEN = 4;

    // Control byte = {6'b0, format, ampm}
    localparam int CTL_AMPM_BIT = 0;
    localparam int CTL_FMT_BIT  = 1;

    function automatic logic [7:0] ctl_pack(input logic fmt, input logic ampm);
        logic [7:0] b;
        b               = 8'h00;
        b[CTL_FMT_BIT]  = fmt;
        b[CTL_AMPM_BIT] = ampm;
        return b;
    endfunction

endpackage

// File: rtl/rtc_ack_watchdog.sv
// Per-access ack watchdog: counts enabled cycles since the last clear and
// flags the cycle that would be the TIMEOUT-th one without an ack.
module rtc_ack_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds the cycles already missed, so this cycle is the TIMEOUT-th
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/rtc_access_sched.sv
// Arbitrates the RTC byte port between periodic time reads and edit commits,
// running each as a four-access burst and committing the mirrors atomically.
module rtc_access_sched
    import rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_SEC = DEF_ADDR_SEC,
    parameter logic [7:0] ADDR_MIN = DEF_ADDR_MIN,
    parameter logic [7:0] ADDR_HR  = DEF_ADDR_HR,
    parameter logic [7:0] ADDR_CTL = DEF_ADDR_CTL,
    parameter int         TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr_req,
    input  logic       hold,
    input  logic [7:0] HC,
    input  logic [7:0] MC,
    input  logic [7:0] SC,
    input  logic       AmPm_in,
    input  logic       format_in,
    output logic [7:0] H,
    output logic [7:0] M,
    output logic [7:0] S,
    output logic       ampm,
    output logic       format,
    output logic       bus_req,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t     r_state;
    logic [1:0] r_idx;
    logic       r_rd_pend;
    logic       r_wr_pend;
    logic       r_wr_burst;
    logic       r_bus_req;
    logic       r_bus_we;
    logic [7:0] r_bus_addr;
    logic [7:0] r_bus_wdata;
    logic       r_err;
    logic [7:0] r_hr;
    logic [7:0] r_min;
    logic [7:0] r_sec;
    logic       r_ampm;
    logic       r_fmt;

    logic [7:0] r_wb_hr;
    logic [7:0] r_wb_min;
    logic [7:0] r_wb_sec;
    logic       r_wb_ampm;
    logic       r_wb_fmt;
    logic [7:0] r_sh_hr;
    logic [7:0] r_sh_min;
    logic [7:0] r_sh_sec;
    logic       r_sh_ampm;
    logic       r_sh_fmt;

    state_t     w_nxt_state;
    logic [1:0] w_nxt_idx;
    logic       w_start_wr;
    logic       w_start_rd;
    logic       w_abort;
    logic       w_nxt_wr;
    logic       w_enter_acc;
    logic [7:0] w_nxt_wdata;
    logic       w_ack_acc;
    logic       w_wd_clear;
    logic       w_wd_en;
    logic       w_wd_expired;

    function automatic logic [7:0] addr_of(input logic [1:0] idx);
        logic [7:0] a;
        unique case (idx)
            2'd0:    a = ADDR_SEC;
            2'd1:    a = ADDR_MIN;
            2'd2:    a = ADDR_HR;
            default: a = ADDR_CTL;
        endcase
        return a;
    endfunction

    assign w_ack_acc  = (r_state == ACC) && bus_ack;
    assign w_wd_clear = (r_state != ACC);
    assign w_wd_en    = (r_state == ACC) && !bus_ack;

    rtc_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_start_wr  = 1'b0;
        w_start_rd  = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A pending write always wins; reads wait while the display holds
                if (r_wr_pend) begin
                    w_start_wr  = 1'b1;
                    w_nxt_state = ACC;
                    w_nxt_idx   = 2'd0;
                end else if (r_rd_pend && !hold) begin
                    w_start_rd  = 1'b1;
                    w_nxt_state = ACC;
                    w_nxt_idx   = 2'd0;
                end
            end
            ACC: begin
                if (bus_ack) begin
                    w_nxt_state = (r_idx == 2'(BURST_LEN - 1)) ? FIN : GAP;
                end else if (w_wd_expired) begin
                    w_abort     = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            GAP: begin
                w_nxt_state = ACC;
                w_nxt_idx   = r_idx + 2'd1;
            end
            FIN: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        w_nxt_wr    = w_start_wr | (r_wr_burst & ~w_start_rd);
        w_enter_acc = (w_nxt_state == ACC);

        w_nxt_wdata = 8'h00;
        if (w_enter_acc && w_nxt_wr) begin
            // On the start edge the buffer is still loading, so take SC directly
            if (w_start_wr) begin
                w_nxt_wdata = SC;
            end else begin
                unique case (w_nxt_idx)
                    2'd0:    w_nxt_wdata = r_wb_sec;
                    2'd1:    w_nxt_wdata = r_wb_min;
                    2'd2:    w_nxt_wdata = r_wb_hr;
                    default: w_nxt_wdata = ctl_pack(r_wb_fmt, r_wb_ampm);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wr_burst  <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 8'h00;
            r_bus_wdata <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_rd_pend   <= (r_rd_pend & ~w_start_rd) | tick;
            r_wr_pend   <= (r_wr_pend & ~w_start_wr) | wr_req;
            r_wr_burst  <= w_nxt_wr;
            r_bus_req   <= w_enter_acc;
            r_bus_we    <= w_enter_acc & w_nxt_wr;
            r_bus_addr  <= w_enter_acc ? addr_of(w_nxt_idx) : 8'h00;
            r_bus_wdata <= w_nxt_wdata;
            r_err       <= w_abort;
        end
    end

    // Mirrors change only on the FIN exit edge so readers never see a torn time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hr   <= 8'h00;
            r_min  <= 8'h00;
            r_sec  <= 8'h00;
            r_ampm <= 1'b0;
            r_fmt  <= 1'b0;
        end else if (r_state == FIN) begin
            if (r_wr_burst) begin
                r_hr   <= r_wb_hr;
                r_min  <= r_wb_min;
                r_sec  <= r_wb_sec;
                r_ampm <= r_wb_ampm;
                r_fmt  <= r_wb_fmt;
            end else begin
                r_hr   <= r_sh_hr;
                r_min  <= r_sh_min;
                r_sec  <= r_sh_sec;
                r_ampm <= r_sh_ampm;
                r_fmt  <= r_sh_fmt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_wr) begin
            r_wb_hr   <= HC;
            r_wb_min  <= MC;
            r_wb_sec  <= SC;
            r_wb_ampm <= AmPm_in;
            r_wb_fmt  <= format_in;
        end
        if (w_ack_acc && !r_wr_burst) begin
            unique case (r_idx)
                2'd0:    r_sh_sec <= bus_rdata;
                2'd1:    r_sh_min <= bus_rdata;
                2'd2:    r_sh_hr  <= bus_rdata;
                default: begin
                    r_sh_ampm <= bus_rdata[CTL_AMPM_BIT];
                    r_sh_fmt  <= bus_rdata[CTL_FMT_BIT];
                end
            endcase
        end
    end

    assign H         = r_hr;
    assign M         = r_min;
    assign S         = r_sec;
    assign ampm      = r_ampm;
    assign format    = r_fmt;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == FIN);
    assign err       = r_err;

endmodule

// File: tb/tb_rtc_access_sched.sv
// Directed and randomized bench for rtc_access_sched, with a behavioural
// RTC chip model answering the register port.
module tb_rtc_access_sched;

    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       wr_req = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] HC = 8'h00;
    logic [7:0] MC = 8'h00;
    logic [7:0] SC = 8'h00;
    logic       AmPm_in = 1'b0;
    logic       format_in = 1'b0;
    logic [7:0] H, M, S;
    logic       ampm, format;
    logic       bus_req, bus_we;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_ack = 1'b0;
    logic       busy, done, err;

    always #5 clk = ~clk;

    rtc_access_sched #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .wr_req(wr_req), .hold(hold),
        .HC(HC), .MC(MC), .SC(SC), .AmPm_in(AmPm_in), .format_in(format_in),
        .H(H), .M(M), .S(S), .ampm(ampm), .format(format),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
        int         cyc;
    } acc_t;

    logic [7:0] mem [0:255];
    acc_t       log_q[$];
    int         ack_wait = 0;
    bit         blk_en = 0;
    logic [7:0] blk_addr = 8'h00;
    int         wcnt = 0;
    int         cyc = 0;
    int         n_done = 0, n_err = 0, n_req = 0, blk_cnt = 0, proto_err = 0;
    int         done_cyc = 0, err_cyc = 0, last_req_cyc = 0, first_rise = -1;
    logic       prev_req = 1'b0;
    logic [16:0] prev_bus = '0;
    int         checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Chip model and bus monitor, acting between clock edges
    always @(negedge clk) begin
        if (!reset) begin
            bus_ack  = 1'b0;
            wcnt     = 0;
            prev_req = 1'b0;
        end else begin
            if (done) begin
                n_done++;
                done_cyc = cyc;
                if (bus_req) proto_err++;
            end
            if (err) begin
                n_err++;
                err_cyc = cyc;
            end
            if (bus_req) begin
                n_req++;
                last_req_cyc = cyc;
                if (!prev_req && first_rise < 0) first_rise = cyc;
                if (!busy) proto_err++;
                if (bus_ack) proto_err++;
                if (prev_req && ({bus_addr, bus_we, bus_wdata} !== prev_bus)) proto_err++;
                if (blk_en && bus_addr == blk_addr) blk_cnt++;
            end
            prev_req = bus_req;
            prev_bus = {bus_addr, bus_we, bus_wdata};
            if (bus_ack) begin
                bus_ack = 1'b0;
            end else if (bus_req) begin
                if (!(blk_en && bus_addr == blk_addr)) begin
                    if (wcnt >= ack_wait) begin
                        bus_ack = 1'b1;
                        wcnt = 0;
                        log_q.push_back('{addr: bus_addr, we: bus_we, wd: bus_wdata, cyc: cyc});
                        if (bus_we) mem[bus_addr] = bus_wdata;
                        else bus_rdata = mem[bus_addr];
                    end else begin
                        wcnt++;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_for(input int nd, input int ne, input int budget);
        int c;
        c = 0;
        while ((n_done < nd || n_err < ne) && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk("wait_bound", c < budget, 1'b1);
        @(negedge clk);
    endtask

    task automatic chk_log(input int base, input bit wr,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] ea[4];
        logic [7:0] eb[4];
        ea = '{8'h21, 8'h22, 8'h23, 8'h24};
        eb = '{b0, b1, b2, b3};
        chk("log_len", log_q.size() >= base + 4, 1'b1);
        if (log_q.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("acc_addr", log_q[base+i].addr, ea[i]);
                chk("acc_we", log_q[base+i].we, wr);
                if (wr) chk("acc_wdata", log_q[base+i].wd, eb[i]);
            end
        end
    endtask

    task automatic chk_mirror(input string tag, input logic [7:0] eh, input logic [7:0] em,
                              input logic [7:0] es, input logic ea, input logic ef);
        chk(tag, {H, M, S, ampm, format}, {eh, em, es, ea, ef});
    endtask

    initial begin
        int c0, nd, ne, nr, mode;
        logic [7:0] eh, em, es;
        logic ea, ef;

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_time", {H, M, S}, 0);
        chk("rst_ctl", {ampm, format, bus_req, bus_we, busy, done, err}, 0);
        chk("rst_bus", {bus_addr, bus_wdata}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Read burst, zero-wait ack
        mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12; mem[8'h24] = 8'h03;
        log_q.delete(); first_rise = -1; nd = n_done;
        tick = 1'b1; c0 = cyc;
        @(negedge clk); tick = 1'b0;
        wait_for(nd + 1, n_err, 100);
        chk("rd_req_latency", first_rise - c0, 2);
        chk("rd_done_latency", done_cyc - c0, 9);
        chk_log(0, 0, 0, 0, 0, 0);
        chk_mirror("rd_mirror", 8'h12, 8'h30, 8'h45, 1'b1, 1'b1);
        chk("rd_busy_after", busy, 1'b0);

        // Write burst with inputs changing mid-burst
        HC = 8'h09; MC = 8'h59; SC = 8'h00; AmPm_in = 1'b0; format_in = 1'b1;
        log_q.delete(); nd = n_done;
        wr_req = 1'b1;
        @(negedge clk); wr_req = 1'b0;
        repeat (3) @(negedge clk);
        HC = 8'h11; MC = 8'h22; SC = 8'h33; AmPm_in = 1'b1; format_in = 1'b0;
        wait_for(nd + 1, n_err, 100);
        chk_log(0, 1, 8'h00, 8'h59, 8'h09, 8'h02);
        chk_mirror("wr_mirror", 8'h09, 8'h59, 8'h00, 1'b0, 1'b1);

        // tick and wr_req together: write, one idle cycle, then read-back
        HC = 8'h07; MC = 8'h41; SC = 8'h26; AmPm_in = 1'b1; format_in = 1'b0;
        log_q.delete(); nd = n_done;
        tick = 1'b1; wr_req = 1'b1;
        @(negedge clk); tick = 1'b0; wr_req = 1'b0;
        wait_for(nd + 2, n_err, 200);
        repeat (10) @(negedge clk);
        chk("both_done_count", n_done - nd, 2);
        chk("both_log_len", log_q.size(), 8);
        chk_log(0, 1, 8'h26, 8'h41, 8'h07, 8'h01);
        chk_log(4, 0, 0, 0, 0, 0);
        if (log_q.size() >= 5) begin
            chk("both_intra_gap", log_q[1].cyc - log_q[0].cyc, 2);
            chk("both_inter_gap", log_q[4].cyc - log_q[3].cyc, 3);
        end
        chk_mirror("both_mirror", 8'h07, 8'h41, 8'h26, 1'b1, 1'b0);

        // hold suppresses reads; ticks collapse to a single burst
        hold = 1'b1; nr = n_req; nd = n_done; log_q.delete();
        repeat (3) begin
            tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("hold_no_req", n_req - nr, 0);
        hold = 1'b0;
        wait_for(nd + 1, n_err, 100);
        repeat (20) @(negedge clk);
        chk("hold_one_burst", n_done - nd, 1);
        chk("hold_log_len", log_q.size(), 4);

        // Ack withheld on the minutes access
        blk_en = 1'b1; blk_addr = 8'h22; blk_cnt = 0;
        mem[8'h21] = 8'h58; mem[8'h22] = 8'h14; mem[8'h23] = 8'h11; mem[8'h24] = 8'h00;
        nd = n_done; ne = n_err;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        wait_for(nd, ne + 1, 600);
        chk("wd_req_cycles", blk_cnt, TIMEOUT);
        chk("wd_err_timing", err_cyc - last_req_cyc, 1);
        chk("wd_no_done", n_done - nd, 0);
        chk("wd_idle", {busy, bus_req}, 0);
        chk_mirror("wd_mirror_kept", 8'h07, 8'h41, 8'h26, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("wd_no_retry", n_err - ne, 1);
        blk_en = 1'b0; nd = n_done;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        wait_for(nd + 1, n_err, 100);
        chk_mirror("wd_recover", 8'h11, 8'h14, 8'h58, 1'b0, 1'b0);

        // Randomized mix of reads, writes and both, with ack wait states
        for (int it = 0; it < 8; it++) begin
            ack_wait = $urandom_range(0, 3);
            for (int a = 8'h21; a <= 8'h24; a++) mem[a] = 8'($urandom);
            HC = 8'($urandom); MC = 8'($urandom); SC = 8'($urandom);
            AmPm_in = 1'($urandom); format_in = 1'($urandom);
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                eh = mem[8'h23]; em = mem[8'h22]; es = mem[8'h21];
                ea = mem[8'h24][0]; ef = mem[8'h24][1];
            end else begin
                eh = HC; em = MC; es = SC; ea = AmPm_in; ef = format_in;
            end
            log_q.delete(); nd = n_done;
            tick = (mode != 1); wr_req = (mode != 0);
            @(negedge clk); tick = 1'b0; wr_req = 1'b0;
            wait_for(nd + ((mode == 2) ? 2 : 1), n_err, 300);
            chk("rnd_log_len", log_q.size(), (mode == 2) ? 8 : 4);
            if (mode != 0) chk_log(0, 1, es, em, eh, {6'b0, ef, ea});
            else chk_log(0, 0, 0, 0, 0, 0);
            chk_mirror("rnd_mirror", eh, em, es, ea, ef);
        end
        ack_wait = 0;
        chk("protocol", proto_err, 0);

        // Asynchronous reset during the hours access
        nd = n_done; ack_wait = 3;
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        c0 = 0;
        while (!(bus_req && bus_addr == 8'h23) && c0 < 50) begin
            @(posedge clk); #1; c0++;
        end
        chk("rst_mid_reached", c0 < 50, 1'b1);
        tick = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_bus", {bus_req, busy, done, err, bus_we, bus_addr, bus_wdata}, 0);
        chk("rst_mid_mirror", {H, M, S, ampm, format}, 0);
        @(negedge clk); tick = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; nr = n_req;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_done", n_done - nd, 0);
        chk("rst_mid_pend_lost", n_req - nr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
